bound_flasher_param: RTL and testbench

BOUND_FLASHER_PARAM -- requirements
Module: bound_flasher_param

---
 rtl/bound_flasher_pkg.sv | 22 ++
 rtl/bf_tick_gen.sv | 37 +++
 rtl/bound_flasher_param.sv | 116 +++++++++++
 tb/tb_bound_flasher_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types for the bound flasher: FSM state encoding and parameter legality check.
package bound_flasher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP_A,
    DN_A,
    UP_B,
    DN_B,
    UP_C,
    DN_C,
    KD_A
  } bf_state_e;

  function automatic bit bf_params_legal(input int unsigned n_led,
                                         input int unsigned mid_lo,
                                         input int unsigned mid_hi);
    return (n_led >= 2) && (n_led <= 64) &&
           (mid_lo >= 1) && (mid_lo < mid_hi) && (mid_hi < n_led);
  endfunction

endpackage

// File: rtl/bf_tick_gen.sv
// Prescaler: asserts tick once every TICK_DIV enabled clocks; count freezes while en=0.
module bf_tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  if ((TICK_DIV < 1) || (TICK_DIV > 65535)) begin : g_bad_div
    $fatal(1, "bf_tick_gen: TICK_DIV out of range 1..65535");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/bound_flasher_param.sv
// Bouncing thermometer lamp bar with flick-driven kickback.
// Optional freeze input enabled by defining BOUND_FLASHER_HOLD_EN.
module bound_flasher_param
  import bound_flasher_pkg::*;
#(
  parameter int unsigned N_LED    = 16,
  parameter int unsigned MID_LO   = 5,
  parameter int unsigned MID_HI   = 10,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flick,
`ifdef BOUND_FLASHER_HOLD_EN
  input  logic             hold,
`endif
  output logic [N_LED-1:0] led,
  output logic             busy
);

  localparam int unsigned LW = $clog2(N_LED + 1);
  localparam logic [LW-1:0] L_TOP = LW'(N_LED);
  localparam logic [LW-1:0] L_LO  = LW'(MID_LO);
  localparam logic [LW-1:0] L_HI  = LW'(MID_HI);

  if (!bf_params_legal(N_LED, MID_LO, MID_HI)) begin : g_bad_params
    $fatal(1, "bound_flasher_param: illegal N_LED/MID_LO/MID_HI combination");
  end

  logic run;
  logic tick;

`ifdef BOUND_FLASHER_HOLD_EN
  assign run = ~hold;
`else
  assign run = 1'b1;
`endif

  bf_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick)
  );

  bf_state_e     state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;

  // lvl_d doubles as the step result, so end-level tests compare the post-step value
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (flick) begin
            lvl_d   = LW'(1);
            state_d = UP_A;
          end
        end
        UP_A: begin
          lvl_d = lvl_q + 1'b1;
          if (flick && ((lvl_d == L_LO) || (lvl_d == L_HI))) state_d = KD_A;
          else if (lvl_d == L_TOP)                            state_d = DN_A;
        end
        DN_A: begin
          lvl_d = lvl_q - 1'b1;
          if (lvl_d == L_LO) state_d = UP_B;
        end
        UP_B: begin
          lvl_d = lvl_q + 1'b1;
          if (lvl_d == L_HI) state_d = flick ? DN_A : DN_B;
        end
        DN_B: begin
          lvl_d = lvl_q - 1'b1;
          if (lvl_d == '0) state_d = UP_C;
        end
        UP_C: begin
          lvl_d = lvl_q + 1'b1;
          if (lvl_d == L_LO) state_d = DN_C;
        end
        DN_C: begin
          lvl_d = lvl_q - 1'b1;
          if (lvl_d == '0) state_d = IDLE;
        end
        KD_A: begin
          lvl_d = lvl_q - 1'b1;
          if (lvl_d == '0) state_d = UP_A;
        end
        default: begin
          state_d = IDLE;
          lvl_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
    end
  end

  always_comb begin
    led  = '0;
    busy = (state_q != IDLE);
    for (int unsigned i = 0; i < N_LED; i++) begin
      led[i] = (LW'(i) < lvl_q);
    end
  end

endmodule

// File: tb/tb_bound_flasher_param.sv
// Directed bench for bound_flasher_param: default-rate instance plus a TICK_DIV=4 instance.
module tb_bound_flasher_param;

  logic        clk;
  logic        rst;
  logic        flick;
  logic        flick4;
  logic [15:0] led;
  logic        busy;
  logic [15:0] led4;
  logic        busy4;
`ifdef BOUND_FLASHER_HOLD_EN
  logic        hold;
  logic        hold4;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int busy_end;
  int eff;

  bound_flasher_param #(.N_LED(16), .MID_LO(5), .MID_HI(10), .TICK_DIV(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flick (flick),
`ifdef BOUND_FLASHER_HOLD_EN
    .hold  (hold),
`endif
    .led   (led),
    .busy  (busy)
  );

  bound_flasher_param #(.N_LED(16), .MID_LO(5), .MID_HI(10), .TICK_DIV(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .flick (flick4),
`ifdef BOUND_FLASHER_HOLD_EN
    .hold  (hold4),
`endif
    .led   (led4),
    .busy  (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] therm(input int l);
    logic [63:0] one;
    one = 64'd1;
    return (l >= 64) ? '1 : ((one << l) - one);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_range(input int a, input int b);
    if (a <= b) begin
      for (int i = a; i <= b; i++) exp_q.push_back(i);
    end else begin
      for (int i = a; i >= b; i--) exp_q.push_back(i);
    end
  endtask

  initial begin
    rst    = 1'b1;
    flick  = 1'b0;
    flick4 = 1'b0;
`ifdef BOUND_FLASHER_HOLD_EN
    hold   = 1'b0;
    hold4  = 1'b0;
`endif
    step();
    step();
    chk("reset_led", {48'd0, led}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_led4", {48'd0, led4}, 64'd0);
    chk("reset_busy4", {63'd0, busy4}, 64'd0);
    rst = 1'b0;

    // idle with no flick
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_led", {48'd0, led}, 64'd0);
      chk("idle_busy", {63'd0, busy}, 64'd0);
    end

    // single flick pulse: full bounce sequence, busy drops on edge 52
    exp_q.delete();
    add_range(1, 16); add_range(15, 5); add_range(6, 10);
    add_range(9, 0);  add_range(1, 5);  add_range(4, 0);
    busy_end = exp_q.size() - 1;
    add_range(0, 0); add_range(0, 0); add_range(0, 0);
    flick = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      flick = 1'b0;
      chk($sformatf("oneshot_led_e%0d", k + 1), {48'd0, led}, therm(exp_q[k]));
      chk($sformatf("oneshot_busy_e%0d", k + 1), {63'd0, busy}, {63'd0, (k < busy_end)});
    end

    // flick held high: repeated low kickback, never above MID_LO lamps
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      add_range(1, 5); add_range(4, 0);
    end
    flick = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      chk($sformatf("held_led_e%0d", k + 1), {48'd0, led}, therm(exp_q[k]));
      chk("held_led_max", {63'd0, (led <= 16'h001F)}, 64'd1);
    end
    flick = 1'b0;
    #3 rst = 1'b1;
    #1 chk("held_rst_led", {48'd0, led}, 64'd0);
    chk("held_rst_busy", {63'd0, busy}, 64'd0);
    #1 rst = 1'b0;
    step();
    chk("held_after_rst_led", {48'd0, led}, 64'd0);

    // flick only on edge 32 (UP_B reaching MID_HI): extra trip down to MID_LO
    exp_q.delete();
    add_range(1, 16); add_range(15, 5); add_range(6, 10);
    add_range(9, 5);  add_range(6, 10);
    add_range(9, 0);  add_range(1, 5);  add_range(4, 0);
    busy_end = exp_q.size() - 1;
    add_range(0, 0);
    flick = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      step();
      flick = (k == 30);
      chk($sformatf("kick_b_led_e%0d", k + 1), {48'd0, led}, therm(exp_q[k]));
      chk($sformatf("kick_b_busy_e%0d", k + 1), {63'd0, busy}, {63'd0, (k < busy_end)});
    end

    // asynchronous reset at lvl=12, then quiet until a new flick
    flick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      flick = 1'b0;
      chk($sformatf("pre_rst_led_e%0d", k), {48'd0, led}, therm(k));
    end
    #3 rst = 1'b1;
    #1 chk("async_rst_led", {48'd0, led}, 64'd0);
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_rst_led", {48'd0, led}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end

    // TICK_DIV=4: one step per 4 clocks; optional hold for 10 clocks at lvl 7
    rst = 1'b1;
    step();
    rst = 1'b0;
    flick4 = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 4) flick4 = 1'b0;
`ifdef BOUND_FLASHER_HOLD_EN
      if (k <= 29)      eff = k;
      else if (k <= 39) eff = 29;
      else              eff = k - 10;
      if (k == 29) hold4 = 1'b1;
      if (k == 39) hold4 = 1'b0;
`else
      eff = k;
`endif
      chk($sformatf("div4_led_e%0d", k), {48'd0, led4}, therm(eff / 4));
      chk($sformatf("div4_busy_e%0d", k), {63'd0, busy4}, {63'd0, (k >= 4)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
